// File: rtl/lane_judge.sv
// N-lane rhythm-game timing judge: grades each lane's button press against a cycle-counted
// hit window opened on beat_tick, and tracks hold notes beat by beat.
module lane_judge #(
    parameter int unsigned N_LANES     = 2,
    parameter int unsigned PERFECT_WIN = 8,
    parameter int unsigned GOOD_WIN    = 20,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_tick,
    input  logic [2*N_LANES-1:0] note_in,
    input  logic [N_LANES-1:0]   click_n,
    output logic [2*N_LANES-1:0] result,
    output logic [N_LANES-1:0]   result_valid,
    output logic [N_LANES-1:0]   hold_active,
    output logic                 accum_now
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    localparam logic [1:0] NoteTap       = 2'b01;
    localparam logic [1:0] NoteHoldStart = 2'b10;
    localparam logic [1:0] NoteHoldMid   = 2'b11;

    localparam logic [1:0] ResPerfect = 2'b00;
    localparam logic [1:0] ResGood    = 2'b01;
    localparam logic [1:0] ResMiss    = 2'b10;
    localparam logic [1:0] ResNoNote  = 2'b11;

    localparam logic [CNT_W-1:0] CntPerfect = CNT_W'(PERFECT_WIN);
    localparam logic [CNT_W-1:0] CntLast    = CNT_W'(GOOD_WIN - 1);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic             sync1_q, sync2_q, hist_q;
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [1:0]       kind_q;
        logic [1:0]       res_q;
        logic             valid_q;
        logic             hold_q;
        logic [1:0]       note;
        logic             press_edge;
        logic             pressed;
        logic             opens_window;

        assign note         = note_in[2*i +: 2];
        assign press_edge   = hist_q & ~sync2_q;
        assign pressed      = ~sync2_q;
        assign opens_window = (note == NoteTap) || (note == NoteHoldStart);

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                hist_q  <= 1'b1;
                state_q <= StIdle;
                cnt_q   <= '0;
                kind_q  <= '0;
                res_q   <= ResNoNote;
                valid_q <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                sync1_q <= click_n[i];
                sync2_q <= sync1_q;
                hist_q  <= sync2_q;
                valid_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (beat_tick) begin
                            if (opens_window) begin
                                state_q <= StWait;
                                cnt_q   <= '0;
                                kind_q  <= note;
                            end else if (note == NoteHoldMid) begin
                                res_q   <= ResMiss;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    StWait: begin
                        if (beat_tick) begin
                            // Overrun: the pending note misses; a HOLD_MIDDLE here is dropped.
                            res_q   <= ResMiss;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            if (opens_window) begin
                                kind_q <= note;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else if (press_edge) begin
                            res_q   <= (cnt_q < CntPerfect) ? ResPerfect : ResGood;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            if (kind_q == NoteHoldStart) begin
                                state_q <= StHold;
                                hold_q  <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else if (cnt_q >= CntLast) begin
                            res_q   <= ResMiss;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StHold: begin
                        if (beat_tick) begin
                            if (note == NoteHoldMid) begin
                                valid_q <= 1'b1;
                                if (pressed) begin
                                    res_q <= ResPerfect;
                                end else begin
                                    res_q   <= ResMiss;
                                    state_q <= StIdle;
                                    hold_q  <= 1'b0;
                                end
                            end else begin
                                hold_q <= 1'b0;
                                if (opens_window) begin
                                    state_q <= StWait;
                                    cnt_q   <= '0;
                                    kind_q  <= note;
                                end else begin
                                    state_q <= StIdle;
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign result[2*i +: 2] = res_q;
        assign result_valid[i]  = valid_q;
        assign hold_active[i]   = hold_q;
    end

    // Built only from registered valids, so it pulses in the same cycle as them.
    assign accum_now = |result_valid;

endmodule
